// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC phase path (phase generator, decoder and
// their benches).
//
// Contents:
//   CODE_W      phase code width
//   PHASE_W     ring-thermometer word width (2**CODE_W)
//   ONES_W      number of contiguous ones in a ring word
//   LEN_W       sweep length counter width
//   PHASE_BASE  ring word for code 0: ONES_W ones at the top of the word
//   phase_gen_state_t  generator FSM states
package tdc_pkg;

    localparam int CODE_W  = 5;
    localparam int PHASE_W = 1 << CODE_W;
    localparam int ONES_W  = 16;
    localparam int LEN_W   = 8;

    localparam logic [PHASE_W-1:0] PHASE_BASE =
        {{ONES_W{1'b1}}, {(PHASE_W - ONES_W){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SWEEP
    } phase_gen_state_t;

endpackage

// File: rtl/phase_ror.sv
// Combinational barrel rotate-right of a phase word by a phase code.
// Used to turn a commanded code into its ring-thermometer word in one cycle.
//
// Ports:
//   word_in   in   PHASE_W  word to rotate
//   amount    in   CODE_W   rotate-right distance
//   word_out  out  PHASE_W  rotated word
module phase_ror
    import tdc_pkg::*;
(
    input  logic [PHASE_W-1:0] word_in,
    input  logic [CODE_W-1:0]  amount,
    output logic [PHASE_W-1:0] word_out
);

    logic [PHASE_W-1:0] stage;

    // Log-depth rotator: stage i rotates by 2**i when amount bit i is set.
    always_comb begin
        stage = word_in;
        for (int i = 0; i < CODE_W; i++) begin
            if (amount[i]) begin
                stage = (stage >> (1 << i)) | (stage << (PHASE_W - (1 << i)));
            end
        end
        word_out = stage;
    end

endmodule

// File: rtl/phase_ring_gen.sv
// Phase-word generator: the encode side of the TDC phase decoder.
// Accepts a phase code over a valid/ready command and drives the matching
// ring-thermometer word, either held statically or swept one ring position
// per cycle. A bubble mask can be XORed onto the output word to exercise the
// decoder's bubble tolerance.
//
// Ports:
//   clk          in   1        system clock
//   rst          in   1        asynchronous active-low reset
//   cmd_valid    in   1        command strobe
//   cmd_ready    out  1        command accepted this cycle when valid
//   cmd_code     in   CODE_W   start phase code
//   cmd_mode     in   1        0 = static hold, 1 = sweep
//   cmd_dir      in   1        0 = code+1 per step, 1 = code-1 per step
//   cmd_len      in   LEN_W    number of words in a sweep
//   bubble_mask  in   PHASE_W  XORed onto the output word
//   phase_out    out  PHASE_W  registered phase word
//   code_out     out  CODE_W   clean code matching phase_out
//   phase_valid  out  1        phase_out carries a commanded word
//   busy         out  1        sweep in progress
//   sweep_done   out  1        pulse with the last sweep word
module phase_ring_gen
    import tdc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CODE_W-1:0]  cmd_code,
    input  logic               cmd_mode,
    input  logic               cmd_dir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [PHASE_W-1:0] bubble_mask,
    output logic [PHASE_W-1:0] phase_out,
    output logic [CODE_W-1:0]  code_out,
    output logic               phase_valid,
    output logic               busy,
    output logic               sweep_done
);

    phase_gen_state_t   state, state_next;
    logic [PHASE_W-1:0] ring, ring_next;
    logic [CODE_W-1:0]  code, code_next;
    logic [LEN_W-1:0]   remaining, remaining_next;
    logic               dir, dir_next;
    logic               valid_next;
    logic               done_next;
    logic               accept;
    logic [PHASE_W-1:0] load_word;

    assign cmd_ready = (state != SWEEP);
    assign busy      = (state == SWEEP);
    assign accept    = cmd_valid & cmd_ready;
    assign code_out  = code;

    phase_ror u_ror (
        .word_in  (PHASE_BASE),
        .amount   (cmd_code),
        .word_out (load_word)
    );

    // Next-state logic. Rotating the ring by one and stepping the code by one
    // together keeps ring == word(code) through the 31 <-> 0 wrap for free.
    always_comb begin
        state_next     = state;
        ring_next      = ring;
        code_next      = code;
        remaining_next = remaining;
        dir_next       = dir;
        valid_next     = phase_valid;
        done_next      = 1'b0;

        case (state)
            SWEEP: begin
                if (dir) begin
                    ring_next = {ring[PHASE_W-2:0], ring[PHASE_W-1]};
                    code_next = code - CODE_W'(1);
                end else begin
                    ring_next = {ring[0], ring[PHASE_W-1:1]};
                    code_next = code + CODE_W'(1);
                end
                remaining_next = remaining - LEN_W'(1);
                if (remaining == LEN_W'(1)) begin
                    state_next = HOLD;
                    done_next  = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    ring_next  = load_word;
                    code_next  = cmd_code;
                    dir_next   = cmd_dir;
                    valid_next = 1'b1;
                    // remaining counts the words still to come after the
                    // first one, so a one-word sweep never enters SWEEP.
                    if (cmd_mode && (cmd_len > LEN_W'(1))) begin
                        state_next     = SWEEP;
                        remaining_next = cmd_len - LEN_W'(1);
                    end else begin
                        state_next     = HOLD;
                        remaining_next = '0;
                        done_next      = cmd_mode && (cmd_len == LEN_W'(1));
                    end
                end
            end
        endcase
    end

    // State and datapath registers. The mask is applied on the way into
    // phase_out only, so the ring itself always stays a clean word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ring        <= PHASE_BASE;
            code        <= '0;
            remaining   <= '0;
            dir         <= 1'b0;
            phase_out   <= PHASE_BASE;
            phase_valid <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state       <= state_next;
            ring        <= ring_next;
            code        <= code_next;
            remaining   <= remaining_next;
            dir         <= dir_next;
            phase_out   <= ring_next ^ bubble_mask;
            phase_valid <= valid_next;
            sweep_done  <= done_next;
        end
    end

endmodule

// File: tb/tb_phase_ring_gen.sv
// Randomized self-checking bench for phase_ring_gen. A behavioural model
// tracks the commanded code and the number of sweep words still to come;
// expected ring words are computed arithmetically from the base pattern.
module tb_phase_ring_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_code = '0;
    logic        cmd_mode = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] bubble_mask = '0;
    logic [31:0] phase_out;
    logic [4:0]  code_out;
    logic        phase_valid;
    logic        busy;
    logic        sweep_done;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int          m_code = 0;
    int          m_left = 0;
    int          m_dir = 0;
    bit          m_valid = 1'b0;
    bit          m_done = 1'b0;
    logic [31:0] m_mask = '0;

    phase_ring_gen dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_mode    (cmd_mode),
        .cmd_dir     (cmd_dir),
        .cmd_len     (cmd_len),
        .bubble_mask (bubble_mask),
        .phase_out   (phase_out),
        .code_out    (code_out),
        .phase_valid (phase_valid),
        .busy        (busy),
        .sweep_done  (sweep_done)
    );

    always #5 clk = ~clk;

    // Ring word for code k: the base pattern rotated right by k.
    function automatic logic [31:0] word_of(input int k);
        logic [63:0] doubled;
        doubled = {32'hFFFF_0000, 32'hFFFF_0000};
        return 32'(doubled >> k);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".phase"}, phase_out, word_of(m_code) ^ m_mask);
        checkOutput({tag, ".code"}, 32'(code_out), 32'(m_code));
        checkOutput({tag, ".valid"}, 32'(phase_valid), 32'(m_valid));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(m_left > 0));
        checkOutput({tag, ".done"}, 32'(sweep_done), 32'(m_done));
        checkOutput({tag, ".ready"}, 32'(cmd_ready), 32'(m_left == 0));
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic stepModel(input bit v, input int code, input bit mode,
                             input bit dir, input int len, input logic [31:0] mask);
        m_mask = mask;
        m_done = 1'b0;
        if (m_left > 0) begin
            m_code = (m_dir != 0) ? (m_code + 31) % 32 : (m_code + 1) % 32;
            m_left--;
            m_done = (m_left == 0);
        end else if (v) begin
            m_code  = code;
            m_dir   = dir;
            m_valid = 1'b1;
            if (mode && len > 1) begin
                m_left = len - 1;
            end else begin
                m_done = mode && (len == 1);
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input bit v, input int code,
                                 input bit mode, input bit dir, input int len,
                                 input logic [31:0] mask);
        cmd_valid   = v;
        cmd_code    = 5'(code);
        cmd_mode    = mode;
        cmd_dir     = dir;
        cmd_len     = 8'(len);
        bubble_mask = mask;
        stepModel(v, code, mode, dir, len, mask);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(tag, 1'b0, 0, 1'b0, 1'b0, 0, '0);
    endtask

    // Asynchronous reset asserted between edges, checked before the next edge.
    task automatic doReset(input string tag);
        cmd_valid   = 1'b0;
        bubble_mask = '0;
        rst = 1'b0;
        #1;
        m_code  = 0;
        m_left  = 0;
        m_dir   = 0;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_mask  = '0;
        checkAll(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] mask;
        int          len;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        checkAll("rst_held");
        @(negedge clk);
        rst = 1'b1;
        idle("idle", 3);
        checkOutput("idle_word", phase_out, 32'hFFFF_0000);

        // Static load of code 1, held for 10 cycles
        applyStimulus("static1", 1'b1, 1, 1'b0, 1'b0, 0, '0);
        checkOutput("static1_word", phase_out, 32'h7FFF_8000);
        idle("static1_hold", 10);
        checkOutput("static1_held", phase_out, 32'h7FFF_8000);

        // Sweep up from 30 across the wrap
        applyStimulus("sweepA", 1'b1, 30, 1'b1, 1'b0, 4, '0);
        checkOutput("sweepA_w0", phase_out, 32'hFFFC_0003);
        checkOutput("sweepA_rdy0", 32'(cmd_ready), 32'd0);
        idle("sweepA", 1);
        checkOutput("sweepA_w1", phase_out, 32'hFFFE_0001);
        idle("sweepA", 1);
        checkOutput("sweepA_w2", phase_out, 32'hFFFF_0000);
        checkOutput("sweepA_done2", 32'(sweep_done), 32'd0);
        idle("sweepA", 1);
        checkOutput("sweepA_w3", phase_out, 32'h7FFF_8000);
        checkOutput("sweepA_done3", 32'(sweep_done), 32'd1);
        checkOutput("sweepA_rdy3", 32'(cmd_ready), 32'd1);
        idle("sweepA_after", 2);

        // Sweep down from 0 across the wrap, then hold at 30
        applyStimulus("sweepB", 1'b1, 0, 1'b1, 1'b1, 3, '0);
        checkOutput("sweepB_w0", phase_out, 32'hFFFF_0000);
        idle("sweepB", 1);
        checkOutput("sweepB_w1", phase_out, 32'hFFFE_0001);
        idle("sweepB", 1);
        checkOutput("sweepB_w2", phase_out, 32'hFFFC_0003);
        idle("sweepB_hold", 3);
        checkOutput("sweepB_code", 32'(code_out), 32'd30);

        // Bubble mask on a static word
        applyStimulus("bubble", 1'b1, 0, 1'b0, 1'b0, 0, 32'h0001_0000);
        checkOutput("bubble_word", phase_out, 32'hFFFE_0000);
        checkOutput("bubble_code", 32'(code_out), 32'd0);
        idle("bubble_clear", 1);
        checkOutput("bubble_cleared", phase_out, 32'hFFFF_0000);

        // One-word sweep and zero-length sweep
        applyStimulus("len1", 1'b1, 7, 1'b1, 1'b0, 1, '0);
        checkOutput("len1_done", 32'(sweep_done), 32'd1);
        applyStimulus("len0", 1'b1, 9, 1'b1, 1'b0, 0, '0);
        idle("len0_hold", 2);

        // Command mid-sweep is ignored
        applyStimulus("mid", 1'b1, 10, 1'b1, 1'b0, 6, '0);
        idle("mid", 2);
        applyStimulus("mid_cmd", 1'b1, 5, 1'b0, 1'b0, 0, '0);
        checkOutput("mid_code", 32'(code_out), 32'd13);
        idle("mid_rest", 4);

        // Reset mid-sweep
        applyStimulus("rstmid", 1'b1, 3, 1'b1, 1'b1, 8, '0);
        idle("rstmid", 2);
        doReset("rstmid_rst");
        checkOutput("rstmid_word", phase_out, 32'hFFFF_0000);
        idle("rstmid_after", 4);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                doReset("rnd_rst");
            end else begin
                mask = '0;
                if ($urandom_range(0, 3) == 0) begin
                    mask = ($urandom_range(0, 1) == 0) ? (32'd1 << $urandom_range(0, 31))
                                                       : 32'($urandom);
                end
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60))
                                                  : int'($urandom_range(0, 5));
                applyStimulus("rnd", $urandom_range(0, 2) == 0,
                              int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), len, mask);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
